// File: rtl/thrscan_pkg.sv
// Shared definitions for the threshold-scan sequencer: FSM state encoding
// and default parameter widths.
package thrscan_pkg;

  localparam int DAC_W_DEF = 10;
  localparam int WIN_W_DEF = 32;
  localparam int CNT_W_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SNAP   = 3'd2,
    ST_COUNT  = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_REPORT = 3'd5,
    ST_STEP   = 3'd6
  } state_t;

endpackage

// File: rtl/thrscan_if.sv
// Result handshake bundle: one (threshold, hit count) pair per scan point.
// The master (sequencer) holds the payload until res_valid & res_ready.
interface thrscan_if
  import thrscan_pkg::*;
#(
  parameter int DAC_W = DAC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic             res_valid;
  logic             res_ready;
  logic [DAC_W-1:0] res_thr;
  logic [CNT_W-1:0] res_count;

  modport master (output res_valid, output res_thr, output res_count, input res_ready);
  modport slave  (input res_valid, input res_thr, input res_count, output res_ready);
endinterface

// File: rtl/thrscan_win_timer.sv
// Loadable down-counter used for both DAC settle time and counting window.
// expired_o is high during the final cycle of a loaded interval, so a
// state that decrements while waiting for expired_o lasts exactly the
// loaded number of cycles (minimum one).
module thrscan_win_timer #(
  parameter int WIN_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIN_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             expired_o
);

  logic [WIN_W-1:0] cnt_q;
  logic [WIN_W-1:0] cnt_d;

  // Next count: a load wins over a decrement; never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIN_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q <= WIN_W'(1));

endmodule

// File: rtl/thrscan_seq.sv
// Threshold-scan sequencer. Steps a discriminator DAC code from thr_first to
// thr_last, settles, opens a counting window on an external free-running hit
// counter and reports the hit count of each window over a valid/ready bus.
// Optional feature: define THRSCAN_ABORT_EN to add an 'abort' input that
// drops any scan in progress and returns to IDLE without a done pulse.
module thrscan_seq
  import thrscan_pkg::*;
#(
  parameter int DAC_W = DAC_W_DEF,
  parameter int WIN_W = WIN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DAC_W-1:0] thr_first,
  input  logic [DAC_W-1:0] thr_last,
  input  logic [DAC_W-1:0] thr_step,
  input  logic [WIN_W-1:0] settle_len,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] cnt_in,
`ifdef THRSCAN_ABORT_EN
  input  logic             abort,
`endif
  output logic [DAC_W-1:0] dac_code,
  output logic             cnt_enb,
  thrscan_if.master        res,
  output logic             busy,
  output logic             done
);

  state_t state_q, state_d;

  logic [DAC_W-1:0] thr_last_q, thr_last_d;
  logic [DAC_W-1:0] step_q, step_d;
  logic [WIN_W-1:0] settle_q, settle_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [DAC_W-1:0] dac_code_q, dac_code_d;
  logic [CNT_W-1:0] snap_q, snap_d;
  logic             res_valid_q, res_valid_d;
  logic [DAC_W-1:0] res_thr_q, res_thr_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             start_acc;
  logic             xfer;
  logic             abort_act;
  logic [DAC_W:0]   next_full;
  logic             last_pt;
  logic [DAC_W-1:0] step_eff;
  logic [WIN_W-1:0] win_eff;

  logic             tmr_load;
  logic [WIN_W-1:0] tmr_val;
  logic             tmr_dec;
  logic             tmr_exp;

`ifdef THRSCAN_ABORT_EN
  assign abort_act = abort && (state_q != ST_IDLE);
`else
  assign abort_act = 1'b0;
`endif

  assign start_acc = start && (state_q == ST_IDLE);
  assign xfer      = res_valid_q && res.res_ready;
  assign step_eff  = (thr_step == '0) ? DAC_W'(1) : thr_step;
  assign win_eff   = (win_len == '0) ? WIN_W'(1) : win_len;

  // Next code is formed one bit wider so a DAC overflow ends the scan
  // instead of wrapping back to a low code.
  assign next_full = {1'b0, dac_code_q} + {1'b0, step_q};
  assign last_pt   = (next_full > {1'b0, thr_last_q});

  thrscan_win_timer #(.WIN_W(WIN_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .expired_o  (tmr_exp)
  );

  // Timer control: settle length loaded on the way into SETTLE, window
  // length loaded in SNAP, counting down while in SETTLE or COUNT.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmr_load = start;
        tmr_val  = settle_len;
      end
      ST_STEP: begin
        tmr_load = 1'b1;
        tmr_val  = settle_q;
      end
      ST_SNAP: begin
        tmr_load = 1'b1;
        tmr_val  = win_q;
      end
      ST_SETTLE, ST_COUNT: tmr_dec = 1'b1;
      default: ;
    endcase
  end

  // Next-state logic for the scan FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = (settle_len != '0) ? ST_SETTLE : ST_SNAP;
      ST_SETTLE: if (tmr_exp) state_d = ST_SNAP;
      ST_SNAP:   state_d = ST_COUNT;
      ST_COUNT:  if (tmr_exp) state_d = ST_DRAIN;
      ST_DRAIN:  state_d = ST_REPORT;
      ST_REPORT: if (xfer) state_d = last_pt ? ST_IDLE : ST_STEP;
      ST_STEP:   state_d = (settle_q != '0) ? ST_SETTLE : ST_SNAP;
      default:   state_d = ST_IDLE;
    endcase
    if (abort_act) state_d = ST_IDLE;
  end

  // Datapath next values: parameter latch, snapshots, result and status.
  always_comb begin
    thr_last_d  = thr_last_q;
    step_d      = step_q;
    settle_d    = settle_q;
    win_d       = win_q;
    dac_code_d  = dac_code_q;
    snap_d      = snap_q;
    res_valid_d = res_valid_q;
    res_thr_d   = res_thr_q;
    res_count_d = res_count_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    if (start_acc) begin
      thr_last_d = thr_last;
      step_d     = step_eff;
      settle_d   = settle_len;
      win_d      = win_eff;
      dac_code_d = thr_first;
      busy_d     = 1'b1;
    end
    case (state_q)
      ST_SNAP: snap_d = cnt_in;
      ST_DRAIN: begin
        // Modular subtraction gives the right count across counter wrap.
        res_count_d = cnt_in - snap_q;
        res_thr_d   = dac_code_q;
        res_valid_d = 1'b1;
      end
      ST_REPORT: begin
        if (xfer) begin
          res_valid_d = 1'b0;
          if (last_pt) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      ST_STEP: dac_code_d = next_full[DAC_W-1:0];
      default: ;
    endcase
    if (abort_act) begin
      res_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr_last_q  <= '0;
      step_q      <= '0;
      settle_q    <= '0;
      win_q       <= '0;
      dac_code_q  <= '0;
      snap_q      <= '0;
      res_valid_q <= 1'b0;
      res_thr_q   <= '0;
      res_count_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      thr_last_q  <= thr_last_d;
      step_q      <= step_d;
      settle_q    <= settle_d;
      win_q       <= win_d;
      dac_code_q  <= dac_code_d;
      snap_q      <= snap_d;
      res_valid_q <= res_valid_d;
      res_thr_q   <= res_thr_d;
      res_count_q <= res_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign dac_code      = dac_code_q;
  assign cnt_enb       = (state_q == ST_COUNT) && !abort_act;
  assign res.res_valid = res_valid_q;
  assign res.res_thr   = res_thr_q;
  assign res.res_count = res_count_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_thrscan_seq.sv
// Directed testbench for thrscan_seq. Models the downstream hit counter as
// a register that increments on every enabled clock (a hit every cycle).
module tb_thrscan_seq;
  import thrscan_pkg::*;

  localparam int DAC_W = 10;
  localparam int WIN_W = 32;
  localparam int CNT_W = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [DAC_W-1:0] thr_first, thr_last, thr_step;
  logic [WIN_W-1:0] settle_len, win_len;
  logic [CNT_W-1:0] cnt_in;
  logic [DAC_W-1:0] dac_code;
  logic             cnt_enb, busy, done;
`ifdef THRSCAN_ABORT_EN
  logic             abort;
`endif

  thrscan_if #(.DAC_W(DAC_W), .CNT_W(CNT_W)) res_bus ();

  thrscan_seq #(.DAC_W(DAC_W), .WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .thr_first  (thr_first),
    .thr_last   (thr_last),
    .thr_step   (thr_step),
    .settle_len (settle_len),
    .win_len    (win_len),
    .cnt_in     (cnt_in),
`ifdef THRSCAN_ABORT_EN
    .abort      (abort),
`endif
    .dac_code   (dac_code),
    .cnt_enb    (cnt_enb),
    .res        (res_bus.master),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Hit counter model and window-length monitor.
  logic             preset_req = 1'b0;
  logic [CNT_W-1:0] preset_val = '0;
  int enb_total = 0, enb_run = 0, enb_last_run = 0;

  always @(posedge clk) begin
    if (preset_req) cnt_in <= preset_val;
    else if (cnt_enb) cnt_in <= cnt_in + 64'd1;
    if (cnt_enb) begin
      enb_run   <= enb_run + 1;
      enb_total <= enb_total + 1;
    end else if (enb_run != 0) begin
      enb_last_run <= enb_run;
      enb_run      <= 0;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [DAC_W-1:0] got_thr[$];
  logic [CNT_W-1:0] got_cnt[$];
  int first_enb;

  // Run one scan to completion; optionally hold res_ready low for 'stall'
  // cycles on the first result and check nothing moves meanwhile.
  task automatic do_scan(input int first, input int last, input int step,
                         input int settle, input int win, input int stall);
    int cyc;
    bit stalled;
    logic [DAC_W-1:0] h_thr;
    logic [CNT_W-1:0] h_cnt;
    int h_tot;
    bit ok_v, ok_t, ok_c, ok_d, ok_e;
    got_thr.delete();
    got_cnt.delete();
    first_enb = -1;
    @(negedge clk);
    thr_first  = DAC_W'(first);
    thr_last   = DAC_W'(last);
    thr_step   = DAC_W'(step);
    settle_len = WIN_W'(settle);
    win_len    = WIN_W'(win);
    res_bus.res_ready = (stall == 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs: the scan must use the values latched at start.
    thr_first = '0; thr_last = '0; thr_step = 10'd3; settle_len = 32'd9; win_len = 32'd2;
    check("busy_after_start", 64'(busy), 64'd1);
    check("dac_code_at_start", 64'(dac_code), 64'(first));
    cyc = 1;
    stalled = 1'b0;
    while (1) begin
      if (cnt_enb && first_enb < 0) first_enb = cyc;
      if (res_bus.res_valid && !res_bus.res_ready && !stalled && stall > 0) begin
        h_thr = res_bus.res_thr;
        h_cnt = res_bus.res_count;
        h_tot = enb_total;
        ok_v = 1; ok_t = 1; ok_c = 1; ok_d = 1; ok_e = 1;
        repeat (stall) begin
          @(negedge clk);
          if (!res_bus.res_valid) ok_v = 0;
          if (res_bus.res_thr != h_thr) ok_t = 0;
          if (res_bus.res_count != h_cnt) ok_c = 0;
          if (dac_code != h_thr) ok_d = 0;
          if (enb_total != h_tot || cnt_enb) ok_e = 0;
        end
        check("stall_valid_held", 64'(ok_v), 64'd1);
        check("stall_thr_held", 64'(ok_t), 64'd1);
        check("stall_count_held", 64'(ok_c), 64'd1);
        check("stall_dac_held", 64'(ok_d), 64'd1);
        check("stall_no_window", 64'(ok_e), 64'd1);
        stalled = 1'b1;
        res_bus.res_ready = 1'b1;
      end
      if (res_bus.res_valid && res_bus.res_ready) begin
        got_thr.push_back(res_bus.res_thr);
        got_cnt.push_back(res_bus.res_count);
      end
      if (done) break;
      if (cyc > 3000) begin
        check("scan_timeout", 64'd0, 64'd1);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    check("busy_low_at_done", 64'(busy), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic expect_res(input string tag, input int idx, input int thr, input longint cnt);
    if (idx < got_thr.size()) begin
      check({tag, "_thr"}, 64'(got_thr[idx]), 64'(thr));
      check({tag, "_cnt"}, got_cnt[idx], 64'(cnt));
    end else begin
      check({tag, "_missing"}, 64'(got_thr.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bit leak;
    rst = 1'b1; start = 1'b0;
    thr_first = '0; thr_last = '0; thr_step = '0; settle_len = '0; win_len = '0;
    res_bus.res_ready = 1'b1;
`ifdef THRSCAN_ABORT_EN
    abort = 1'b0;
`endif
    preset_val = '0;
    preset_req = 1'b1;
    repeat (3) @(negedge clk);
    preset_req = 1'b0;
    check("rst_dac_code", 64'(dac_code), 64'd0);
    check("rst_cnt_enb", 64'(cnt_enb), 64'd0);
    check("rst_res_valid", 64'(res_bus.res_valid), 64'd0);
    check("rst_res_thr", 64'(res_bus.res_thr), 64'd0);
    check("rst_res_count", res_bus.res_count, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Three-point scan with settle time.
    do_scan(10, 14, 2, 4, 100, 0);
    check("t1_nres", 64'(got_thr.size()), 64'd3);
    expect_res("t1_r0", 0, 10, 100);
    expect_res("t1_r1", 1, 12, 100);
    expect_res("t1_r2", 2, 14, 100);
    check("t1_first_enb_cycle", 64'(first_enb), 64'd6);
    check("t1_window_len", 64'(enb_last_run), 64'd100);

    // Hit counter wraps during the window.
    @(negedge clk);
    preset_val = 64'hFFFF_FFFF_FFFF_FFFB;
    preset_req = 1'b1;
    @(negedge clk);
    preset_req = 1'b0;
    do_scan(5, 5, 1, 0, 10, 0);
    check("t2_nres", 64'(got_thr.size()), 64'd1);
    expect_res("t2_r0", 0, 5, 10);

    // Back-pressure on the first result.
    do_scan(3, 4, 1, 1, 5, 50);
    check("t3_nres", 64'(got_thr.size()), 64'd2);
    expect_res("t3_r0", 0, 3, 5);
    expect_res("t3_r1", 1, 4, 5);

    // DAC overflow ends the scan; zero window still enables one cycle.
    do_scan(1020, 1023, 5, 2, 0, 0);
    check("t4_nres", 64'(got_thr.size()), 64'd1);
    expect_res("t4_r0", 0, 1020, 1);
    check("t4_window_len", 64'(enb_last_run), 64'd1);
    check("t4_first_enb_cycle", 64'(first_enb), 64'd4);

    // Next code wraps past DAC_W to a value below thr_last.
    do_scan(1000, 1023, 30, 0, 3, 0);
    check("t5_nres", 64'(got_thr.size()), 64'd1);
    expect_res("t5_r0", 0, 1000, 3);

    // thr_first above thr_last: one point.
    do_scan(7, 3, 0, 0, 2, 0);
    check("t6_nres", 64'(got_thr.size()), 64'd1);
    expect_res("t6_r0", 0, 7, 2);

    // Zero step behaves as one.
    do_scan(8, 9, 0, 0, 4, 0);
    check("t7_nres", 64'(got_thr.size()), 64'd2);
    expect_res("t7_r0", 0, 8, 4);
    expect_res("t7_r1", 1, 9, 4);

    // Reset in the middle of a counting window.
    @(negedge clk);
    thr_first = 10'd50; thr_last = 10'd60; thr_step = 10'd1;
    settle_len = 32'd0; win_len = 32'd100;
    res_bus.res_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!cnt_enb && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("t8_reached_count", 64'(cnt_enb), 64'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t8_rst_dac_code", 64'(dac_code), 64'd0);
    check("t8_rst_cnt_enb", 64'(cnt_enb), 64'd0);
    check("t8_rst_res_valid", 64'(res_bus.res_valid), 64'd0);
    check("t8_rst_res_thr", 64'(res_bus.res_thr), 64'd0);
    check("t8_rst_res_count", res_bus.res_count, 64'd0);
    check("t8_rst_busy", 64'(busy), 64'd0);
    check("t8_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    leak = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (res_bus.res_valid || busy || cnt_enb || done) leak = 1'b1;
    end
    check("t8_no_partial_after_rst", 64'(leak), 64'd0);
    do_scan(20, 20, 1, 1, 7, 0);
    check("t8_nres", 64'(got_thr.size()), 64'd1);
    expect_res("t8_r0", 0, 20, 7);

`ifdef THRSCAN_ABORT_EN
    // Abort while a result is waiting in REPORT.
    @(negedge clk);
    thr_first = 10'd30; thr_last = 10'd40; thr_step = 10'd1;
    settle_len = 32'd0; win_len = 32'd3;
    res_bus.res_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!res_bus.res_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("t9_reached_report", 64'(res_bus.res_valid), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t9_abort_valid", 64'(res_bus.res_valid), 64'd0);
    check("t9_abort_busy", 64'(busy), 64'd0);
    check("t9_abort_done", 64'(done), 64'd0);
    res_bus.res_ready = 1'b1;
    leak = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || res_bus.res_valid || cnt_enb) leak = 1'b1;
    end
    check("t9_no_done_after_abort", 64'(leak), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/thrscan_seq.md
THRSCAN_SEQ -- requirements
Module: thrscan_seq

Interface
REQ-001 SHALL have parameter DAC_W, default 10, threshold DAC code width.
REQ-002 SHALL have parameter WIN_W, default 32, window/settle length width.
REQ-003 SHALL have parameter CNT_W, default 64, hit-counter width.
REQ-004 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle scan start pulse.
REQ-007 SHALL have port thr_first  in  DAC_W  first threshold code.
REQ-008 SHALL have port thr_last  in  DAC_W  final threshold code, inclusive.
REQ-009 SHALL have port thr_step  in  DAC_W  code increment.
REQ-010 SHALL have port settle_len  in  WIN_W  DAC settle cycles before each window.
REQ-011 SHALL have port win_len  in  WIN_W  counting-window length in cycles.
REQ-012 SHALL have port cnt_in  in  CNT_W  free-running output of downstream hit counter.
REQ-013 SHALL have port dac_code  out  DAC_W  threshold applied to discriminator.
REQ-014 SHALL have port cnt_enb  out  1  counter enable, high only inside window.
REQ-015 SHALL have port res_valid / res_ready  out / in  1  result handshake.
REQ-016 SHALL have port res_thr  out  DAC_W  threshold of current result.
REQ-017 SHALL have port res_count  out  CNT_W  hits counted in that window.
REQ-018 SHALL have ports busy  out  1  scan in progress; done  out  1  one-cycle pulse after final result accepted.

Function
REQ-019 SHALL latch thr_first/thr_last/thr_step/settle_len/win_len on accepted start; later input changes ignored until next scan.
REQ-020 SHALL implement FSM IDLE -> SETTLE -> SNAP -> COUNT -> DRAIN -> REPORT -> (STEP -> SETTLE | IDLE).
REQ-021 SHALL accept start only in IDLE; start while busy ignored.
REQ-022 SHALL hold dac_code constant from SETTLE entry through REPORT exit.
REQ-023 SHALL stay in SETTLE exactly settle_len cycles; settle_len 0 skips SETTLE.
REQ-024 SHALL capture cnt_in as start snapshot in SNAP (cnt_enb low).
REQ-025 SHALL assert cnt_enb exactly max(win_len,1) consecutive cycles in COUNT.
REQ-026 SHALL spend one DRAIN cycle (counter registered lag), then capture end snapshot.
REQ-027 SHALL set res_count = end - start modulo 2^CNT_W, correct across counter wrap.
REQ-028 SHALL hold res_valid, res_thr, res_count stable until res_valid & res_ready; transfer on that edge.
REQ-029 SHALL compute next code in DAC_W+1 bits; scan ends when next > thr_last or overflows DAC_W.
REQ-030 SHALL treat thr_step 0 as 1; thr_first > thr_last yields one point at thr_first.
REQ-031 SHALL pulse done one cycle after final transfer and deassert busy same cycle; busy high from cycle after start to then.

Reset
REQ-032 SHALL, on rst, asynchronously enter IDLE, clear dac_code, cnt_enb, res_valid, res_thr, res_count, busy, done to 0.
REQ-033 SHALL abandon any scan on mid-operation reset; no partial result emitted after release.

Configuration
REQ-034 SHALL, with THRSCAN_ABORT_EN defined, add input abort (1 bit): high in any non-IDLE state forces cnt_enb low, drops res_valid, returns to IDLE next cycle, no done pulse.
REQ-035 SHALL, without THRSCAN_ABORT_EN, have no abort port; scans always run to completion.

Structure
REQ-036 SHALL place FSM state enum and default width constants in package thrscan_pkg.
REQ-037 SHALL use sub-module thrscan_win_timer (loadable down-counter, expiry flag) for settle and window timing.

Verification
REQ-038 first=10,last=14,step=2,win=100,settle=4, hits every cycle -> three results (10,100),(12,100),(14,100), then done.
REQ-039 cnt_in preset 2^64-5, win=10, hits every cycle -> res_count=10 despite wrap.
REQ-040 res_ready low 50 cycles -> res_valid, res_thr, res_count unchanged, dac_code held, no next window.
REQ-041 first=1020,last=1023,step=5,DAC_W=10 -> single result at 1020; win=0 -> cnt_enb high exactly 1 cycle.
REQ-042 rst asserted mid-COUNT -> all outputs 0 immediately; new start after release gives clean scan.
REQ-043 THRSCAN_ABORT_EN, abort in REPORT -> res_valid low next cycle, IDLE, no done.
